// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
//   lsu_state_e : bus transaction FSM states
//   LB..SW      : funct3 encodings for loads and stores
//   lsu_lane_t  : store-side byte enables plus lane-replicated data
package lsu_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BE_W   = WORD_W / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } lsu_state_e;

  // Load encodings
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  // Store encodings
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef struct packed {
    logic [BE_W-1:0]   be;
    logic [WORD_W-1:0] wdata;
  } lsu_lane_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the load/store unit.
//   funct3/offset/store_data/is_store : request being issued (store lane + fault)
//   load_funct3/load_offset/load_word : latched load info plus bus response word
//   lane_c      : byte enables and replicated store data for the request
//   load_data_c : extracted, extended load result
//   fault_c     : misaligned access or illegal funct3 for the request
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]        funct3,
  input  logic [1:0]        offset,
  input  logic [WORD_W-1:0] store_data,
  input  logic              is_store,
  input  logic [2:0]        load_funct3,
  input  logic [1:0]        load_offset,
  input  logic [WORD_W-1:0] load_word,
  output lsu_lane_t         lane_c,
  output logic [WORD_W-1:0] load_data_c,
  output logic              fault_c
);

  logic [WORD_W-1:0] shifted;
  logic              illegal;
  logic              misaligned;

  // Store byte enables and lane replication; loads always fetch the whole word
  always_comb begin
    lane_c.be    = BE_W'(4'b1111);
    lane_c.wdata = store_data;
    if (is_store) begin
      case (funct3)
        SB: begin
          lane_c.be    = BE_W'(4'b0001) << offset;
          lane_c.wdata = {4{store_data[7:0]}};
        end
        SH: begin
          lane_c.be    = BE_W'(4'b0011) << {offset[1], 1'b0};
          lane_c.wdata = {2{store_data[15:0]}};
        end
        default: begin
          lane_c.be    = BE_W'(4'b1111);
          lane_c.wdata = store_data;
        end
      endcase
    end
  end

  // Bring the addressed lane down to bit 0, then extend by access type
  always_comb begin
    shifted = load_word >> {load_offset, 3'b000};
    case (load_funct3)
      LB:      load_data_c = {{24{shifted[7]}}, shifted[7:0]};
      LH:      load_data_c = {{16{shifted[15]}}, shifted[15:0]};
      LBU:     load_data_c = {24'd0, shifted[7:0]};
      LHU:     load_data_c = {16'd0, shifted[15:0]};
      default: load_data_c = load_word;
    endcase
  end

  // funct3[1:0] encodes the size for both loads and stores
  always_comb begin
    illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
    case (funct3[1:0])
      2'b01:   misaligned = offset[0];
      2'b10:   misaligned = |offset;
      default: misaligned = 1'b0;
    endcase
    fault_c = illegal || misaligned;
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit bridging a single-cycle core to a request/grant/response bus.
//   clock, reset        : clock and asynchronous active-low reset
//   lsu_read/lsu_write  : access request (both high is a store)
//   lsu_funct3/addr/wdata : access size/sign, byte address, store data
//   lsu_rdata           : registered, extended load data (held until next load)
//   lsu_stall           : freezes the core while an access is outstanding
//   lsu_fault           : misaligned or illegal access seen in IDLE
//   mem_*               : word-aligned bus request and response
// Only DATA_W = 32 is supported.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              lsu_read,
  input  logic              lsu_write,
  input  logic [2:0]        lsu_funct3,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [DATA_W-1:0] lsu_wdata,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic              lsu_stall,
  output logic              lsu_fault,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);

  lsu_state_e        state_q, state_d;
  logic [1:0]        offset_q, offset_d;
  logic [2:0]        funct3_q, funct3_d;
  logic              mem_req_d, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [3:0]        mem_be_d;
  logic [DATA_W-1:0] mem_wdata_d, lsu_rdata_d;

  logic              access;
  logic              resp_done;
  lsu_lane_t         lane_c;
  logic [DATA_W-1:0] load_data_c;
  logic              fault_c;

  assign access = lsu_read || lsu_write;

  lsu_align u_align (
    .funct3      (lsu_funct3),
    .offset      (lsu_addr[1:0]),
    .store_data  (lsu_wdata),
    .is_store    (lsu_write),
    .load_funct3 (funct3_q),
    .load_offset (offset_q),
    .load_word   (mem_rdata),
    .lane_c      (lane_c),
    .load_data_c (load_data_c),
    .fault_c     (fault_c)
  );

  // Fault and stall are only meaningful for a request being presented in IDLE
  assign lsu_fault = (state_q == IDLE) && access && fault_c;
  assign lsu_stall = ((state_q == IDLE) && access && !fault_c) ||
                     (state_q == REQ) || (state_q == RESP);

  // Next state, latched request fields and registered bus outputs
  always_comb begin
    state_d     = state_q;
    offset_d    = offset_q;
    funct3_d    = funct3_q;
    mem_we_d    = mem_we;
    mem_addr_d  = mem_addr;
    mem_be_d    = mem_be;
    mem_wdata_d = mem_wdata;
    lsu_rdata_d = lsu_rdata;
    // Responses only count while a transaction is outstanding
    resp_done   = mem_rvalid && (((state_q == REQ) && mem_gnt) || (state_q == RESP));

    case (state_q)
      IDLE: begin
        if (access && !fault_c) begin
          state_d     = REQ;
          offset_d    = lsu_addr[1:0];
          funct3_d    = lsu_funct3;
          mem_we_d    = lsu_write;
          mem_addr_d  = {lsu_addr[ADDR_W-1:2], 2'b00};
          mem_be_d    = lane_c.be;
          mem_wdata_d = lane_c.wdata;
        end
      end
      REQ: begin
        if (mem_gnt) state_d = mem_rvalid ? DONE : RESP;
      end
      RESP: begin
        if (mem_rvalid) state_d = DONE;
      end
      DONE: begin
        // Always drop back so the held instruction is not re-issued
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (resp_done && !mem_we) lsu_rdata_d = load_data_c;
    mem_req_d = (state_d == REQ);
  end

  // State and output registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      offset_q  <= 2'd0;
      funct3_q  <= 3'd0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= 4'd0;
      mem_wdata <= '0;
      lsu_rdata <= '0;
    end else begin
      state_q   <= state_d;
      offset_q  <= offset_d;
      funct3_q  <= funct3_d;
      mem_req   <= mem_req_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_be    <= mem_be_d;
      mem_wdata <= mem_wdata_d;
      lsu_rdata <= lsu_rdata_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: expected load results are queued at
// issue and compared when the unit reaches DONE.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        lsu_read = 1'b0, lsu_write = 1'b0;
  logic [2:0]  lsu_funct3 = 3'd0;
  logic [31:0] lsu_addr = 32'd0, lsu_wdata = 32'd0;
  logic [31:0] lsu_rdata;
  logic        lsu_stall, lsu_fault;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'd0;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] model_rdata = 32'd0;
  logic [31:0] exp_q[$];

  load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clock      (clock),
    .reset      (reset),
    .lsu_read   (lsu_read),
    .lsu_write  (lsu_write),
    .lsu_funct3 (lsu_funct3),
    .lsu_addr   (lsu_addr),
    .lsu_wdata  (lsu_wdata),
    .lsu_rdata  (lsu_rdata),
    .lsu_stall  (lsu_stall),
    .lsu_fault  (lsu_fault),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic exp_fault(input logic [2:0] f3, input logic [31:0] a);
    case (f3)
      3'b001, 3'b101: return a[0];
      3'b010:         return a[1:0] != 2'b00;
      3'b011, 3'b110, 3'b111: return 1'b1;
      default:        return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] exp_be(input logic wr, input logic [2:0] f3, input logic [31:0] a);
    if (!wr) return 4'b1111;
    if (f3 == 3'b000) begin
      case (a[1:0])
        2'd0: return 4'b0001;
        2'd1: return 4'b0010;
        2'd2: return 4'b0100;
        default: return 4'b1000;
      endcase
    end
    if (f3 == 3'b001) return a[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic wr, input logic [2:0] f3, input logic [31:0] d);
    if (wr && f3 == 3'b000) return {d[7:0], d[7:0], d[7:0], d[7:0]};
    if (wr && f3 == 3'b001) return {d[15:0], d[15:0]};
    return d;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0: b = w[7:0];
      2'd1: b = w[15:8];
      2'd2: b = w[23:16];
      default: b = w[31:24];
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000: return {{24{b[7]}}, b};
      3'b001: return {{16{h[15]}}, h};
      3'b100: return {24'd0, b};
      3'b101: return {16'd0, h};
      default: return w;
    endcase
  endfunction

  // Issue one access, act as the bus, and check the unit throughout
  task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d,
                        input int gnt_at, input int rv_at, input logic [31:0] word);
    logic        flt;
    logic        done;
    int          stalls;
    logic [31:0] exp;
    flt = exp_fault(f3, a);
    @(negedge clock);
    lsu_read = rd; lsu_write = wr; lsu_funct3 = f3; lsu_addr = a; lsu_wdata = d;
    #1;
    check("issue_fault", 32'(lsu_fault), 32'(flt));
    check("issue_stall", 32'(lsu_stall), 32'(!flt));
    if (flt) begin
      @(negedge clock);
      #1;
      check("fault_no_req", 32'(mem_req), 32'd0);
      check("fault_no_stall", 32'(lsu_stall), 32'd0);
      check("fault_rdata_hold", lsu_rdata, model_rdata);
      lsu_read = 1'b0; lsu_write = 1'b0;
      return;
    end
    if (!wr) model_rdata = exp_load(f3, a[1:0], word);
    exp_q.push_back(model_rdata);
    stalls = 0;
    done   = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clock);
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom();
      #1;
      if (!lsu_stall) begin
        done = 1'b1;
        break;
      end
      stalls++;
      check("mem_req", 32'(mem_req), 32'(n <= gnt_at));
      if (n <= gnt_at) begin
        check("mem_addr", mem_addr, a & 32'hFFFF_FFFC);
        check("mem_be", 32'(mem_be), 32'(exp_be(wr, f3, a)));
        check("mem_wdata", mem_wdata, exp_wdata(wr, f3, d));
        check("mem_we", 32'(mem_we), 32'(wr));
      end
      mem_gnt    = (n == gnt_at);
      mem_rvalid = (n == rv_at);
      if (n == rv_at) mem_rdata = word;
    end
    check("done_reached", 32'(done), 32'd1);
    check("stall_cycles", 32'(stalls), 32'(rv_at + 1));
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hXXXX_XXXX;
    check("done_rdata", lsu_rdata, exp);
    check("done_no_req", 32'(mem_req), 32'd0);
    lsu_read = 1'b0; lsu_write = 1'b0;
    @(negedge clock);
    #1;
    check("idle_stall", 32'(lsu_stall), 32'd0);
    check("idle_rdata_hold", lsu_rdata, model_rdata);
  endtask

  initial begin
    // Reset values
    repeat (3) @(negedge clock);
    #1;
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_be", 32'(mem_be), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_rdata", lsu_rdata, 32'd0);
    check("rst_stall", 32'(lsu_stall), 32'd0);
    reset = 1'b1;

    // Reset asserted while waiting in RESP; late response must be dropped
    @(negedge clock);
    lsu_read = 1'b1; lsu_funct3 = LW; lsu_addr = 32'h300;
    @(negedge clock);
    #1;
    check("rr_req", 32'(mem_req), 32'd1);
    mem_gnt = 1'b1;
    @(negedge clock);
    mem_gnt = 1'b0;
    #1;
    check("rr_resp_stall", 32'(lsu_stall), 32'd1);
    reset = 1'b0; lsu_read = 1'b0;
    #1;
    check("rr_req_clr", 32'(mem_req), 32'd0);
    check("rr_stall_clr", 32'(lsu_stall), 32'd0);
    check("rr_addr_clr", mem_addr, 32'd0);
    @(negedge clock);
    reset = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    @(negedge clock);
    mem_rvalid = 1'b0;
    #1;
    check("rr_late_rdata", lsu_rdata, 32'd0);
    check("rr_late_stall", 32'(lsu_stall), 32'd0);
    check("rr_late_req", 32'(mem_req), 32'd0);

    //     rd    wr    f3   addr          wdata          gnt rv  word
    access(1'b1, 1'b0, LW,  32'h0000_0100, 32'h0,         0, 2, 32'hDEAD_BEEF);
    access(1'b1, 1'b0, LB,  32'h0000_0103, 32'h0,         0, 1, 32'h8000_0000);
    access(1'b1, 1'b0, LBU, 32'h0000_0103, 32'h0,         1, 1, 32'h8000_0000);
    access(1'b0, 1'b1, SH,  32'h0000_0202, 32'h1234_ABCD, 0, 0, 32'h0);
    access(1'b1, 1'b0, LW,  32'h0000_0101, 32'h0,         0, 0, 32'h0);
    access(1'b1, 1'b0, LW,  32'h0000_0104, 32'h0,         0, 0, 32'h1234_5678);
    access(1'b0, 1'b1, SB,  32'h0000_0201, 32'h5566_77EF, 2, 3, 32'h0);
    access(1'b1, 1'b0, LH,  32'h0000_0102, 32'h0,         0, 1, 32'h8001_5555);
    access(1'b1, 1'b0, LHU, 32'h0000_0100, 32'h0,         1, 2, 32'h1234_F00D);
    access(1'b1, 1'b1, SW,  32'h0000_010C, 32'hA5A5_0FF0, 0, 1, 32'h0);
    access(1'b1, 1'b0, 3'b011, 32'h0000_0000, 32'h0,      0, 0, 32'h0);
    access(1'b1, 1'b0, 3'b110, 32'h0000_0000, 32'h0,      0, 0, 32'h0);
    access(1'b0, 1'b1, SW,  32'h0000_0102, 32'h0,         0, 0, 32'h0);
    access(1'b0, 1'b1, SH,  32'h0000_0203, 32'h0,         0, 0, 32'h0);
    access(1'b1, 1'b0, LH,  32'h0000_0101, 32'h0,         0, 0, 32'h0);
    access(1'b1, 1'b0, LB,  32'h0000_0082, 32'h0,         1, 4, 32'h0012_7F00);
    access(1'b1, 1'b0, LW,  32'h0000_0400, 32'h0,         3, 3, 32'h0BAD_CAFE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
